// File: rtl/traffic_light_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl_pkg
//   Shared definitions for the four-approach traffic-light controller:
//   controller state encoding (3 bits) and lamp colour constants.
//   Lamp vectors are {red, yellow, green}.
// -----------------------------------------------------------------------------
package traffic_light_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_ALLRED_A  = 3'd0,   // clearance before NS green
    ST_NS_GREEN  = 3'd1,
    ST_NS_YELLOW = 3'd2,
    ST_ALLRED_B  = 3'd3,   // clearance before EW green
    ST_EW_GREEN  = 3'd4,
    ST_EW_YELLOW = 3'd5,
    ST_PED_WALK  = 3'd6,
    ST_FLASH     = 3'd7
  } state_t;

  localparam logic [2:0] LED_RED = 3'b100;
  localparam logic [2:0] LED_YEL = 3'b010;
  localparam logic [2:0] LED_GRN = 3'b001;
  localparam logic [2:0] LED_OFF = 3'b000;

  // True for the two clearance states from which the walk / flash branches start.
  function automatic logic is_allred(input state_t s);
    return (s == ST_ALLRED_A) || (s == ST_ALLRED_B);
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_tick_gen.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl_tick_gen
//   Free-running prescaler producing a one-clk "second" tick.
//   Ports:
//     clk    in  system clock
//     rst_n  in  asynchronous active-low reset (counter cleared to 0)
//     tick   out 1 for one clk when the prescaler sits at CLK_PER_SEC-1
// -----------------------------------------------------------------------------
module traffic_light_ctrl_tick_gen #(
  parameter int CLK_PER_SEC = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int               CNT_W   = (CLK_PER_SEC > 2) ? $clog2(CLK_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_PER_SEC - 1);

  logic [CNT_W-1:0] count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (count_reg == CNT_MAX) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign tick = (count_reg == CNT_MAX);

endmodule

// File: rtl/traffic_light_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_light_ctrl
//   Four-approach traffic-light controller. Sequences NS/EW green-yellow-all-red
//   phases, inserts an all-red pedestrian walk phase on request and offers a
//   night flashing-yellow mode. All timing is counted in 1 s ticks.
//   Ports:
//     clk         in   system clock
//     rst_n       in   asynchronous active-low reset
//     ped_req     in   pedestrian button (level or pulse, clk-synchronous)
//     night_mode  in   request flashing-yellow operation
//     led_east    out  {red,yellow,green} east approach
//     led_west    out  {red,yellow,green} west approach (same as east)
//     led_south   out  {red,yellow,green} south approach
//     led_north   out  {red,yellow,green} north approach (same as south)
//     ped_walk    out  walk indication
//     ped_pend    out  latched pedestrian request awaiting service
//     remain_sec  out  ticks remaining in current state (0 while flashing)
// -----------------------------------------------------------------------------
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int CLK_PER_SEC = 50_000_000,
  parameter int GREEN_S     = 20,
  parameter int YELLOW_S    = 3,
  parameter int ALLRED_S    = 2,
  parameter int PED_S       = 10,
  parameter int SEC_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ped_req,
  input  logic             night_mode,
  output logic [2:0]       led_east,
  output logic [2:0]       led_west,
  output logic [2:0]       led_south,
  output logic [2:0]       led_north,
  output logic             ped_walk,
  output logic             ped_pend,
  output logic [SEC_W-1:0] remain_sec
);

  logic             tick;

  state_t           state_reg,   state_next;
  logic [SEC_W-1:0] remain_reg,  remain_next;
  logic             flash_reg,   flash_next;
  logic             ret_ew_reg,  ret_ew_next;   // 1: walk returns to EW green
  logic             pend_reg,    pend_next;
  logic [2:0]       led_ns_reg,  led_ns_next;
  logic [2:0]       led_ew_reg,  led_ew_next;
  logic             walk_reg,    walk_next;

  traffic_light_ctrl_tick_gen #(
    .CLK_PER_SEC (CLK_PER_SEC)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Countdown value loaded on entry to a state (duration minus one).
  function automatic logic [SEC_W-1:0] dur_m1(input state_t s);
    case (s)
      ST_NS_GREEN, ST_EW_GREEN:   dur_m1 = SEC_W'(GREEN_S - 1);
      ST_NS_YELLOW, ST_EW_YELLOW: dur_m1 = SEC_W'(YELLOW_S - 1);
      ST_ALLRED_A, ST_ALLRED_B:   dur_m1 = SEC_W'(ALLRED_S - 1);
      ST_PED_WALK:                dur_m1 = SEC_W'(PED_S - 1);
      default:                    dur_m1 = '0;   // FLASH shows 0
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    remain_next = remain_reg;
    flash_next  = flash_reg;
    ret_ew_next = ret_ew_reg;

    if (tick) begin
      if (state_reg == ST_FLASH) begin
        // Flash phase advances every tick; leaving always restarts at ALLRED_A
        // with the lamps dark-phase reset.
        if (!night_mode) begin
          state_next = ST_ALLRED_A;
          flash_next = 1'b0;
        end else begin
          flash_next = ~flash_reg;
        end
      end else if (remain_reg != '0) begin
        remain_next = remain_reg - SEC_W'(1);
      end else begin
        case (state_reg)
          ST_NS_GREEN:  state_next = ST_NS_YELLOW;
          ST_NS_YELLOW: state_next = ST_ALLRED_B;
          ST_EW_GREEN:  state_next = ST_EW_YELLOW;
          ST_EW_YELLOW: state_next = ST_ALLRED_A;
          ST_ALLRED_A, ST_ALLRED_B: begin
            // Night and walk requests are only honoured here so that a
            // running green/yellow is never cut short.
            if (night_mode) begin
              state_next = ST_FLASH;
            end else if (pend_reg) begin
              state_next  = ST_PED_WALK;
              ret_ew_next = (state_reg == ST_ALLRED_B);
            end else begin
              state_next = (state_reg == ST_ALLRED_B) ? ST_EW_GREEN : ST_NS_GREEN;
            end
          end
          ST_PED_WALK:  state_next = ret_ew_reg ? ST_EW_GREEN : ST_NS_GREEN;
          default:      state_next = state_reg;
        endcase
      end
    end

    if (state_next != state_reg) begin
      remain_next = dur_m1(state_next);
    end
  end

  // Pedestrian latch: entering the walk clears it even if the button is held
  // in that same cycle; presses during the walk are ignored.
  always_comb begin
    pend_next = pend_reg;
    if ((state_next == ST_PED_WALK) && (state_reg != ST_PED_WALK)) begin
      pend_next = 1'b0;
    end else if (ped_req && (state_reg != ST_PED_WALK)) begin
      pend_next = 1'b1;
    end
  end

  // Lamp decode from the registered state; the result is registered again so
  // the pins never see decode glitches.
  always_comb begin
    led_ns_next = LED_RED;
    led_ew_next = LED_RED;
    walk_next   = 1'b0;
    case (state_reg)
      ST_NS_GREEN:  led_ns_next = LED_GRN;
      ST_NS_YELLOW: led_ns_next = LED_YEL;
      ST_EW_GREEN:  led_ew_next = LED_GRN;
      ST_EW_YELLOW: led_ew_next = LED_YEL;
      ST_PED_WALK:  walk_next   = 1'b1;
      ST_FLASH: begin
        led_ns_next = flash_reg ? LED_YEL : LED_OFF;
        led_ew_next = flash_reg ? LED_YEL : LED_OFF;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_ALLRED_A;
      remain_reg <= SEC_W'(ALLRED_S - 1);
      flash_reg  <= 1'b0;
      ret_ew_reg <= 1'b0;
      pend_reg   <= 1'b0;
      led_ns_reg <= LED_RED;
      led_ew_reg <= LED_RED;
      walk_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      remain_reg <= remain_next;
      flash_reg  <= flash_next;
      ret_ew_reg <= ret_ew_next;
      pend_reg   <= pend_next;
      led_ns_reg <= led_ns_next;
      led_ew_reg <= led_ew_next;
      walk_reg   <= walk_next;
    end
  end

  assign led_east   = led_ew_reg;
  assign led_west   = led_ew_reg;
  assign led_south  = led_ns_reg;
  assign led_north  = led_ns_reg;
  assign ped_walk   = walk_reg;
  assign ped_pend   = pend_reg;
  assign remain_sec = remain_reg;

endmodule
